// File: rtl/traffic_light_nway_if.sv
// Sensor/tick inputs and lamp/status outputs of the N-way traffic-light controller.
interface traffic_light_nway_if #(
    parameter int N_WAYS = 4
);
    logic                      tick;
    logic [N_WAYS-1:0]         sensor;
    logic [2*N_WAYS-1:0]       lights;
    logic [$clog2(N_WAYS)-1:0] active_way;
    logic [1:0]                phase;

    modport master (output tick, sensor, input lights, active_way, phase);
    modport slave  (input tick, sensor, output lights, active_way, phase);
endinterface

// File: rtl/traffic_light_nway.sv
// N-approach traffic-light controller: timed green/yellow/all-red phases on a tick
// timebase, latched per-approach demand and round-robin service of waiting approaches.
module traffic_light_nway_lane #(
    parameter int IDX = 0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       sensor,
    input  logic       clr,
    input  logic       own,
    input  logic [1:0] nxt_phase,
    output logic       demand,
    output logic [1:0] lamp
);
    localparam logic [1:0] L_GREEN  = 2'b00;
    localparam logic [1:0] L_YELLOW = 2'b01;
    localparam logic [1:0] L_RED    = 2'b11;

    // Lamp is decoded from the next state so it changes on the same edge as phase.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            demand <= 1'b0;
            lamp   <= (IDX == 0) ? L_GREEN : L_RED;
        end else begin
            demand <= clr ? 1'b0 : (demand | sensor);
            if (!own)                    lamp <= L_RED;
            else if (nxt_phase == 2'b00) lamp <= L_GREEN;
            else if (nxt_phase == 2'b01) lamp <= L_YELLOW;
            else                         lamp <= L_RED;
        end
    end
endmodule

module traffic_light_nway #(
    parameter int N_WAYS    = 4,
    parameter int CNT_W     = 8,
    parameter int GREEN_MIN = 10,
    parameter int GREEN_MAX = 40,
    parameter int YELLOW_T  = 4,
    parameter int ALLRED_T  = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    traffic_light_nway_if.slave  bus
);
    localparam int AW = $clog2(N_WAYS);
    localparam logic [1:0] PH_GREEN  = 2'b00;
    localparam logic [1:0] PH_YELLOW = 2'b01;
    localparam logic [1:0] PH_ALLRED = 2'b10;
    localparam logic [CNT_W:0]   G_MIN  = (CNT_W+1)'(GREEN_MIN);
    localparam logic [CNT_W:0]   G_MAX  = (CNT_W+1)'(GREEN_MAX);
    localparam logic [CNT_W:0]   Y_T    = (CNT_W+1)'(YELLOW_T);
    localparam logic [CNT_W:0]   AR_T   = (CNT_W+1)'(ALLRED_T);
    localparam logic [CNT_W-1:0] T_SAT  = {CNT_W{1'b1}};

    logic [1:0]              phase_q, nxt_phase;
    logic [AW-1:0]           way_q, nxt_way, pick_way;
    logic [CNT_W-1:0]        timer_q, nxt_timer;
    logic [CNT_W:0]          t;
    logic                    enter_green, other;
    logic [N_WAYS-1:0]       demand, clr_vec, own_vec;
    logic [N_WAYS-1:0][1:0]  lamp;

    genvar g;
    generate
        for (g = 0; g < N_WAYS; g++) begin : g_lane
            traffic_light_nway_lane #(.IDX(g)) u_lane (
                .clk       (clk),
                .reset_n   (reset_n),
                .sensor    (bus.sensor[g]),
                .clr       (clr_vec[g]),
                .own       (own_vec[g]),
                .nxt_phase (nxt_phase),
                .demand    (demand[g]),
                .lamp      (lamp[g])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase_q <= PH_GREEN;
            way_q   <= '0;
            timer_q <= '0;
        end else begin
            phase_q <= nxt_phase;
            way_q   <= nxt_way;
            timer_q <= nxt_timer;
        end
    end

    always_comb begin
        other = 1'b0;
        for (int i = 0; i < N_WAYS; i++)
            if (way_q != AW'(i) && demand[i]) other = 1'b1;
    end

    // Scan from the farthest distance down so the nearest waiting approach after
    // the current owner wins; the owner itself is distance N_WAYS (checked first).
    always_comb begin
        pick_way = way_q;
        for (int d = N_WAYS; d >= 1; d--)
            for (int k = 0; k < N_WAYS; k++)
                if (way_q == AW'(k) && demand[(k + d) % N_WAYS])
                    pick_way = AW'((k + d) % N_WAYS);
    end

    always_comb begin
        t           = {1'b0, timer_q} + {{CNT_W{1'b0}}, 1'b1};
        nxt_phase   = phase_q;
        nxt_way     = way_q;
        enter_green = 1'b0;
        case (phase_q)
            PH_GREEN:
                if (bus.tick && t >= G_MIN && other && (!bus.sensor[way_q] || t >= G_MAX))
                    nxt_phase = PH_YELLOW;
            PH_YELLOW:
                if (bus.tick && t == Y_T) nxt_phase = PH_ALLRED;
            PH_ALLRED:
                if (bus.tick && t == AR_T) begin
                    nxt_phase   = PH_GREEN;
                    nxt_way     = pick_way;
                    enter_green = 1'b1;
                end
            default: begin
                nxt_phase   = PH_GREEN;
                enter_green = 1'b1;
            end
        endcase
    end

    always_comb begin
        nxt_timer = timer_q;
        if (phase_q == 2'b11 || nxt_phase != phase_q) nxt_timer = '0;
        else if (bus.tick && timer_q != T_SAT)        nxt_timer = timer_q + 1'b1;
        for (int i = 0; i < N_WAYS; i++) begin
            own_vec[i] = (nxt_way == AW'(i));
            clr_vec[i] = enter_green && (nxt_way == AW'(i));
        end
    end

    assign bus.lights     = lamp;
    assign bus.phase      = phase_q;
    assign bus.active_way = way_q;
endmodule

// File: tb/tb_traffic_light_nway.sv
// Directed scoreboard bench: the driver queues the expected per-cycle outputs,
// a negedge monitor pops and compares them and also checks lamp exclusivity.
module tb_traffic_light_nway;
    logic clk = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    traffic_light_nway_if #(.N_WAYS(4)) bus ();

    traffic_light_nway #(
        .N_WAYS(4), .CNT_W(8), .GREEN_MIN(3), .GREEN_MAX(6), .YELLOW_T(2), .ALLRED_T(1)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        logic [7:0] lights;
        logic [1:0] phase;
        logic [1:0] way;
        string      tag;
        int         n;
    } exp_t;

    exp_t  q[$];
    int    errors = 0;
    int    checks = 0;
    int    vec_n  = 0;
    string cur    = "init";
    bit    en     = 1'b0;

    task automatic st(input logic rst, input logic tk, input logic [3:0] sen,
                      input logic [7:0] l, input logic [1:0] ph, input logic [1:0] w,
                      input int reps);
        exp_t e;
        for (int r = 0; r < reps; r++) begin
            @(posedge clk);
            #1;
            reset_n    = rst;
            bus.tick   = tk;
            bus.sensor = (r == 0) ? sen : (sen & 4'b0001 & {4{cur == "maxgreen"}});
            e.lights = l; e.phase = ph; e.way = w; e.tag = cur; e.n = vec_n;
            q.push_back(e);
            vec_n++;
            en = 1'b1;
        end
    endtask

    task automatic rst2(input string name);
        cur   = name;
        vec_n = 0;
        st(1'b0, 1'b1, 4'b0000, 8'hFC, 2'b00, 2'd0, 2);
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            if (bus.lights !== e.lights || bus.phase !== e.phase || bus.active_way !== e.way) begin
                errors++;
                $display("FAIL %s#%0d: got lights=%h phase=%b way=%0d, want lights=%h phase=%b way=%0d",
                         e.tag, e.n, bus.lights, bus.phase, bus.active_way, e.lights, e.phase, e.way);
            end
        end
        if (en) begin
            int nonred;
            nonred = 0;
            for (int i = 0; i < 4; i++)
                if (bus.lights[2*i +: 2] !== 2'b11) nonred++;
            checks++;
            if (nonred > 1) begin
                errors++;
                $display("FAIL exclusive: lights=%h has %0d non-red approaches, want at most 1",
                         bus.lights, nonred);
            end
        end
    end

    initial begin
        bus.tick   = 1'b0;
        bus.sensor = 4'b0000;
        #1 reset_n = 1'b0;

        rst2("reset");
        st(1, 1, 4'b0000, 8'hFC, 2'b00, 2'd0, 21);

        rst2("single");
        st(1, 1, 4'b0100, 8'hFC, 2'b00, 2'd0, 1);
        st(1, 1, 4'b0000, 8'hFC, 2'b00, 2'd0, 2);
        st(1, 1, 4'b0000, 8'hFD, 2'b01, 2'd0, 2);
        st(1, 1, 4'b0000, 8'hFF, 2'b10, 2'd0, 1);
        st(1, 1, 4'b0000, 8'hCF, 2'b00, 2'd2, 6);

        rst2("maxgreen");
        st(1, 1, 4'b0011, 8'hFC, 2'b00, 2'd0, 1);
        st(1, 1, 4'b0001, 8'hFC, 2'b00, 2'd0, 5);
        st(1, 1, 4'b0001, 8'hFD, 2'b01, 2'd0, 2);
        st(1, 1, 4'b0001, 8'hFF, 2'b10, 2'd0, 1);
        st(1, 1, 4'b0001, 8'hF3, 2'b00, 2'd1, 3);
        st(1, 1, 4'b0001, 8'hF7, 2'b01, 2'd1, 2);
        st(1, 1, 4'b0001, 8'hFF, 2'b10, 2'd1, 1);
        st(1, 1, 4'b0001, 8'hFC, 2'b00, 2'd0, 3);

        rst2("rrobin");
        st(1, 1, 4'b1010, 8'hFC, 2'b00, 2'd0, 1);
        st(1, 1, 4'b0000, 8'hFC, 2'b00, 2'd0, 2);
        st(1, 1, 4'b0000, 8'hFD, 2'b01, 2'd0, 2);
        st(1, 1, 4'b0000, 8'hFF, 2'b10, 2'd0, 1);
        st(1, 1, 4'b0000, 8'hF3, 2'b00, 2'd1, 3);
        st(1, 1, 4'b0000, 8'hF7, 2'b01, 2'd1, 2);
        st(1, 1, 4'b0000, 8'hFF, 2'b10, 2'd1, 1);
        st(1, 1, 4'b0000, 8'h3F, 2'b00, 2'd3, 4);

        // Ticks on every third cycle: green 0..6, yellow 7..12, all-red 13..15, then way 1.
        rst2("tickgate");
        for (int c = 0; c < 22; c++) begin
            logic       tk;
            logic [3:0] sen;
            tk  = (c % 3 == 0);
            sen = (c == 0) ? 4'b0010 : 4'b0000;
            if (c <= 6)       st(1, tk, sen, 8'hFC, 2'b00, 2'd0, 1);
            else if (c <= 12) st(1, tk, sen, 8'hFD, 2'b01, 2'd0, 1);
            else if (c <= 15) st(1, tk, sen, 8'hFF, 2'b10, 2'd0, 1);
            else              st(1, tk, sen, 8'hF3, 2'b00, 2'd1, 1);
        end

        // Reach yellow on way 2 with way 3 pending, then reset: demand for way 3 must be gone.
        rst2("rst_yellow");
        st(1, 1, 4'b0100, 8'hFC, 2'b00, 2'd0, 1);
        st(1, 1, 4'b0000, 8'hFC, 2'b00, 2'd0, 2);
        st(1, 1, 4'b0000, 8'hFD, 2'b01, 2'd0, 2);
        st(1, 1, 4'b0000, 8'hFF, 2'b10, 2'd0, 1);
        st(1, 1, 4'b1000, 8'hCF, 2'b00, 2'd2, 1);
        st(1, 1, 4'b0000, 8'hCF, 2'b00, 2'd2, 2);
        st(1, 1, 4'b0000, 8'hDF, 2'b01, 2'd2, 1);
        st(0, 1, 4'b0000, 8'hFC, 2'b00, 2'd0, 2);
        st(1, 1, 4'b0000, 8'hFC, 2'b00, 2'd0, 10);

        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected entries left unchecked, want 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/traffic_light_nway.md
Name: traffic_light_nway

Overview:
Parametrised N-approach traffic-light controller. It extends the two-way sensor-driven intersection FSM with the following:
- any number of approaches
- timed green/yellow/all-red phases, counted on an external timebase tick
- latched per-approach demand
- round-robin service among the approaches that are waiting

It sits between the debounced sensor inputs and the lamp drivers. Lamp encoding is unchanged: green 2'b00, yellow 2'b01, red 2'b11.

Parameters:
N_WAYS, 4, number of approaches (2..8)
CNT_W, 8, width of the phase timer
GREEN_MIN, 10, minimum green duration in ticks (>=1)
GREEN_MAX, 40, maximum green duration in ticks when another approach is waiting (>=GREEN_MIN)
YELLOW_T, 4, yellow duration in ticks (>=1)
ALLRED_T, 2, all-red clearance duration in ticks (>=1)

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
tick  input  1  one-cycle timebase strobe; all timing advances only on cycles with tick=1
sensor  input  N_WAYS  traffic-present per approach, level, synchronous to clk
lights  output  2*N_WAYS  lamp code of approach i on bits [2i+1:2i]; registered
active_way  output  $clog2(N_WAYS)  approach currently owning green/yellow; also the last owner during all-red; registered
phase  output  2  00 GREEN, 01 YELLOW, 10 ALLRED; 11 unused; registered

Behaviour:
- Reset (asynchronous, reset_n=0), all values hold while reset_n is low:
  - phase=GREEN, active_way=0, timer=0, demand=0
  - lights: approach 0 green, all others red
- Demand latch:
  - demand[i] is set on any clk where sensor[i]=1.
  - demand[active_way] is cleared on the cycle the FSM enters GREEN for that approach. A set on the same cycle is ignored for the entering approach.
  - other = OR of demand[j] for all j != active_way.
- Timer:
  - Increments on tick, saturating at 2^CNT_W-1.
  - Clears to 0 on every phase change.
  - "t" below means timer+1, evaluated on a tick cycle.
- GREEN(k), evaluated only when tick=1:
  - If t < GREEN_MIN: stay.
  - Else if other=0: stay indefinitely (rest in green). The timer keeps counting but never forces an exit.
  - Else if sensor[k]=0 or t >= GREEN_MAX: go to YELLOW.
  - Else: stay.
- YELLOW(k): on the tick where t == YELLOW_T, go to ALLRED.
- ALLRED(k): on the tick where t == ALLRED_T:
  - active_way <= the first j in k+1, k+2, ... (mod N_WAYS) with demand[j]=1; go to GREEN.
  - If demand is all zero, which can only occur through an N_WAYS=… corner, re-enter GREEN(k).
- Lights per phase:
  - GREEN(k): approach k = 00, all others = 11.
  - YELLOW(k): approach k = 01, all others = 11.
  - ALLRED: all approaches = 11.
  - No two approaches are ever non-red simultaneously, in any cycle.
- Output timing: lights, phase and active_way update on the clk edge where the transition is taken, i.e. one cycle after the deciding tick is sampled.
- tick=0: no state or timer change. Demand still latches.
- Reset mid-phase (any phase, any timer value): immediate return to the reset state; pending demand is lost.
- Illegal phase encoding 11: recover to GREEN(active_way) with timer=0 on the next clk.

Test Plan:
Common setup: N_WAYS=4, GREEN_MIN=3, GREEN_MAX=6, YELLOW_T=2, ALLRED_T=1, CNT_W=8, tick=1 every cycle unless noted.
1. Reset: release reset_n with sensor=0 -> lights=8'hFC, phase=00, active_way=0. Run 20 cycles with no sensor -> lights stays 8'hFC throughout.
2. Single request: one-cycle pulse on sensor[2] at cycle 0 -> lights sequence:
   - 8'hFC for 3 cycles
   - 8'hFD for 2 cycles
   - 8'hFF for 1 cycle
   - then 8'hCF, active_way=2, rests there
3. Max green: sensor[0] held at 1, sensor[1] pulsed at cycle 0 -> green on way 0 for exactly 6 ticks, then 8'hFD, 8'hFF, then 8'hF3.
4. Round robin: way 0 green; pulse sensor[3] and sensor[1] together -> service order is way 1 (8'hF3), then way 3 (8'h3F). Way 2 is never green. A check in every cycle confirms at most one lamp field is non-11.
5. Tick gating: tick asserted every 3rd cycle, single request on sensor[1] -> every phase duration in clk cycles is 3x the tick count. State is frozen between ticks.
6. Reset mid-yellow: assert reset_n=0 while phase=01 on way 2 -> lights=8'hFC asynchronously. After release, demand is clear and the controller rests on way 0.
